// File: rtl/instr_register_pkg.sv
// Shared types for the executing instruction register.
// Operand/result widths, opcode encoding and the stored entry layout.
package instr_register_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] result_t;
  typedef logic [4:0]              address_t;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;

  function automatic logic is_div_op(opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

  function automatic result_t sext(operand_t x);
    return {{(RES_W-OP_W){x[OP_W-1]}}, x};
  endfunction

endpackage

// File: rtl/instr_div_iter.sv
// Iterative signed divider: restoring division on magnitudes, one
// quotient bit per RUN cycle, signs applied in FIX where done pulses.
// Ports: clk, rst_n, start, a, b, is_mod -> done, result (64-bit).
module instr_div_iter
  import instr_register_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic               is_mod,
  output logic               done,
  output logic [63:0]        result
);

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          mod_q, mod_d;
  logic          nq_q, nq_d;
  logic          nr_q, nr_d;
  logic          bz_q, bz_d;

  logic [32:0]   rem_sh;
  logic [32:0]   diff;
  logic [31:0]   ua;
  logic [31:0]   ub;
  logic [31:0]   mag;
  logic [63:0]   mag_x;
  logic          neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    mod_d   = mod_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    bz_d    = bz_q;

    // Magnitudes fit in 32 unsigned bits, including -2^31.
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;

    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          quo_d   = ua;
          rem_d   = '0;
          dvs_d   = ub;
          mod_d   = is_mod;
          nq_d    = a[31] ^ b[31];
          nr_d    = a[31];
          bz_d    = (b == '0);
        end
      end
      S_RUN: begin
        quo_d = {quo_q[30:0], ~diff[32]};
        rem_d = diff[32] ? rem_sh[31:0]
                         : diff[31:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_CYCLES - 1))
          state_d = S_FIX;
      end
      S_FIX: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Quotient sign is the xor; remainder follows the dividend.
    mag    = mod_q ? rem_q : quo_q;
    neg    = mod_q ? nr_q : nq_q;
    mag_x  = {32'd0, mag};
    done   = (state_q == S_FIX);
    result = bz_q ? '0
                  : (neg ? (~mag_x + 64'd1) : mag_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      bz_q    <= bz_d;
    end
  end

endmodule

// File: rtl/instr_register_exec.sv
// 32-entry instruction store that executes each written op and writes
// the result back; clk/reset_n, write side (load_en, write_pointer,
// operands, opcode, busy), read side (read_pointer -> word, valid).
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_en,
  input  logic [4:0]         write_pointer,
  input  logic signed [31:0] operand_a,
  input  logic signed [31:0] operand_b,
  input  logic [2:0]         opcode,
  output logic               busy,
  input  logic [4:0]         read_pointer,
  output instruction_t       instruction_word,
  output logic               read_valid
);

  instruction_t     mem_q [DEPTH];
  instruction_t     mem_d [DEPTH];
  logic [DEPTH-1:0] val_q, val_d;

  logic     s1_vld_q, s1_vld_d;
  address_t s1_addr_q, s1_addr_d;
  opcode_t  s1_op_q, s1_op_d;
  operand_t s1_a_q, s1_a_d;
  operand_t s1_b_q, s1_b_d;

  logic     div_live_q, div_live_d;
  address_t div_addr_q, div_addr_d;
  logic     busy_q, busy_d;
  logic     wb_q, wb_d;

  opcode_t  op_in;
  logic     accept;
  logic     div_go;
  logic     div_done;
  result_t  div_res;
  result_t  s2_res;

  instr_div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk    (clk),
    .rst_n  (reset_n),
    .start  (div_go),
    .a      (operand_a),
    .b      (operand_b),
    .is_mod (op_in == MOD),
    .done   (div_done),
    .result (div_res)
  );

  always_comb begin
    op_in  = opcode_t'(opcode);
    accept = load_en & ~busy_q;
    div_go = accept & is_div_op(op_in);

    s2_res = '0;
    unique case (s1_op_q)
      ZERO:    s2_res = '0;
      PASSA:   s2_res = sext(s1_a_q);
      PASSB:   s2_res = sext(s1_b_q);
      ADD:     s2_res = sext(s1_a_q) + sext(s1_b_q);
      SUB:     s2_res = sext(s1_a_q) - sext(s1_b_q);
      MULT:    s2_res = sext(s1_a_q) * sext(s1_b_q);
      default: s2_res = '0;
    endcase

    mem_d = mem_q;
    val_d = val_q;

    if (s1_vld_q) begin
      mem_d[s1_addr_q].rezultat = s2_res;
      val_d[s1_addr_q]          = 1'b1;
    end

    if (div_done && div_live_q) begin
      mem_d[div_addr_q].rezultat = div_res;
      val_d[div_addr_q]          = 1'b1;
    end

    // A new write lands last, so it overrides any older
    // writeback aimed at the same entry this edge.
    if (accept) begin
      mem_d[write_pointer] = '{
        opc:      op_in,
        op_a:     operand_a,
        op_b:     operand_b,
        rezultat: '0
      };
      val_d[write_pointer] = 1'b0;
    end

    s1_vld_d  = accept & ~is_div_op(op_in);
    s1_addr_d = write_pointer;
    s1_op_d   = op_in;
    s1_a_d    = operand_a;
    s1_b_d    = operand_b;

    div_live_d = div_live_q;
    div_addr_d = div_addr_q;
    if (div_go) begin
      div_live_d = 1'b1;
      div_addr_d = write_pointer;
    end else if (div_done) begin
      div_live_d = 1'b0;
    end else if (accept && write_pointer == div_addr_q) begin
      div_live_d = 1'b0;
    end

    // busy drops one cycle after the divider writes back.
    wb_d   = div_done;
    busy_d = busy_q;
    if (div_go)
      busy_d = 1'b1;
    else if (wb_q)
      busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      val_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_op_q    <= ZERO;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      div_live_q <= 1'b0;
      div_addr_q <= '0;
      busy_q     <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      val_q      <= val_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      div_live_q <= div_live_d;
      div_addr_q <= div_addr_d;
      busy_q     <= busy_d;
      wb_q       <= wb_d;
    end
  end

  assign busy             = busy_q;
  assign instruction_word = mem_q[read_pointer];
  assign read_valid       = val_q[read_pointer];

endmodule

// File: doc/instr_register_exec.md
Name: instr_register_exec

Overview:
- Responder side of the instruction-register write/read protocol: a 32-entry instruction store that executes each written instruction and writes the result back into the same entry.
- Sits between the stimulus/initiator (load_en, write_pointer, operands, opcode) and the result reader (read_pointer -> instruction_word).
- Single-cycle ops use a 2-stage pipeline; DIV/MOD use an iterative divider that stalls new writes through a busy handshake.

Parameters:
- DEPTH, 32, number of instruction entries (address_t width = $clog2(DEPTH)).
- DIV_CYCLES, 32, iterations per DIV/MOD (one quotient bit per cycle).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- load_en  input  1  write request; accepted only when busy=0
- write_pointer  input  5  entry to write
- operand_a  input  32  signed operand A (operand_t)
- operand_b  input  32  signed operand B (operand_t)
- opcode  input  3  opcode_t: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
- busy  output  1  divider occupied; load_en ignored while high
- read_pointer  input  5  entry to read
- instruction_word  output  instruction_t  {opc, op_a, op_b, rezultat} of entry[read_pointer], combinational read
- read_valid  output  1  entry[read_pointer] holds a completed result

Behaviour:
- Reset (async, reset_n=0): all entries cleared to opc=ZERO, operands=0, rezultat=0, valid=0; pipeline and divider idle; busy=0; read_valid=0. Reset mid-division aborts it with no writeback.
- Accept at rising edge N when load_en=1 and busy=0: entry[wp] gets {opcode, a, b, rezultat=0}, valid[wp]=0.
- Non-divide ops: stage1 registers the op at edge N. Stage2 computes and writes back at edge N+1. Result is visible with read_valid=1 from after edge N+1 (2-cycle latency). Back-to-back accepts every cycle are allowed.
- Arithmetic: rezultat is result_t, signed 64-bit, computed from sign-extended operands.
  - ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=a*b (full 64-bit product).
  - DIV=a/b, truncating toward zero. MOD=a%b, remainder takes the sign of the dividend.
  - Divide by zero: DIV and MOD both yield 0 and still take DIV_CYCLES cycles.
- DIV/MOD: on accept, busy rises after edge N. The divider FSM runs IDLE -> RUN (DIV_CYCLES cycles, magnitude restoring division) -> FIX (apply signs, write back) -> IDLE. busy falls in the cycle after writeback. Total latency is DIV_CYCLES+2 edges.
- Stage1 and divider are separate paths. A non-divide op accepted in the same cycle a DIV starts cannot happen, since only one accept occurs per edge.
- Hazard: if a new accept targets the address held in stage1 or in the divider, that older operation's writeback is discarded. The newest write always wins, and valid reflects the newest op.
- Divider writeback and stage2 writeback in the same edge to different entries both commit.
- read_pointer is fully decoded (all 32 values legal). Reads of a pending entry return the new operands, rezultat=0, read_valid=0.
- load_en while busy=1 is dropped silently with no state change. The initiator must hold its request until busy=0.

Decomposition:
- Package instr_register_pkg holds operand_t (signed 32), result_t (signed 64), opcode_t enum (3-bit, ZERO=0..MOD=7), address_t (5), instruction_t struct {opc, op_a, op_b, rezultat}.
- One sub-module: instr_div_iter. Ports: start, signed a/b, is_mod, done, result; it owns the IDLE/RUN/FIX FSM and a DIV_CYCLES counter.

Test Plan:
- Reset then read all 32 entries -> each returns opc=ZERO, op_a=0, op_b=0, rezultat=0, read_valid=0.
- Write addr 3 ADD a=-7 b=5, then addr 4 MULT a=-15 b=15 on consecutive cycles -> after 2 edges entry3 rezultat=-2 and entry4 rezultat=-225, both read_valid=1.
- Write addr 9 DIV a=-15 b=4 -> busy high for 34 cycles; load_en of addr 10 during busy is ignored; then entry9 rezultat=-3. Repeat with MOD -> rezultat=-3.
- DIV a=12 b=0 to addr 1 -> rezultat=0, read_valid=1, busy duration unchanged.
- Hazard: MULT a=6 b=7 to addr 5, next cycle PASSB b=9 to addr 5 -> final entry5 rezultat=9 and opc=PASSB, never 42 after the second write.
- Assert reset_n mid-DIV (cycle 10 of RUN) -> busy=0 immediately, all entries cleared, no late writeback after release.
